// File: rtl/branch_resolve_pkg.sv
// Shared definitions for branch resolution.
// This package holds the branch op encodings that the decoder also uses,
// the resolve FSM state encodings, and the default PC width.
package branch_resolve_pkg;

  localparam int unsigned AW_DEF = 16;

  typedef enum logic [1:0] {
    BR_BEQ = 2'b00,
    BR_BNE = 2'b01,
    BR_JMP = 2'b10,
    BR_NOP = 2'b11
  } br_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRedir = 2'b01,
    StFlush = 2'b10
  } br_state_e;

  // Taken decision for a decoded branch, given the comparator flag.
  function automatic logic br_is_taken(br_op_e op, logic eq);
    unique case (op)
      BR_BEQ:  return eq;
      BR_BNE:  return ~eq;
      BR_JMP:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve_br_stat_ctr.sv
// Wrapping statistics counter.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset, clears the count
//   i_inc    add one this cycle
//   o_cnt    current count; wraps modulo 2^CW
module branch_resolve_br_stat_ctr #(
  parameter int unsigned CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution.
// This block decides whether an accepted branch is taken. For a taken branch it
// issues a one-cycle fetch redirect, then holds flush for FLUSH_CYC cycles in
// total; the redirect cycle counts as the first of those cycles.
// Ports:
//   i_clk, i_rst_n         clock and asynchronous active-low reset
//   i_br_valid/o_br_ready  request handshake; ready only while idle
//   i_br_op, i_eq          decoded op and comparator equality flag
//   i_pc_seq, i_pc_tgt     fall-through PC (debug only) and target PC
//   o_redirect             one-cycle pulse: fetch loads o_redirect_pc
//   o_redirect_pc          last taken target; holds between redirects
//   o_flush                squash younger instructions in IF/ID
//   o_taken_cnt, o_br_cnt  wrapping statistics counters
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CW        = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_br_valid,
  output logic          o_br_ready,
  input  logic [1:0]    i_br_op,
  input  logic          i_eq,
  input  logic [AW-1:0] i_pc_seq,
  input  logic [AW-1:0] i_pc_tgt,
  output logic          o_redirect,
  output logic [AW-1:0] o_redirect_pc,
  output logic          o_flush,
  output logic [CW-1:0] o_taken_cnt,
  output logic [CW-1:0] o_br_cnt
);

  if (FLUSH_CYC < 1 || FLUSH_CYC > 15) begin : g_bad_flush_cyc
    $error("branch_resolve: FLUSH_CYC must be in 1..15");
  end

  br_state_e     r_state, w_state_d;
  logic [3:0]    r_fcnt, w_fcnt_d;
  logic [AW-1:0] r_redirect_pc;

  br_op_e w_op;
  logic   w_accept, w_take, w_count;
  logic   w_unused_pc_seq;

  // Fall-through PC is already fetched; it never feeds the redirect.
  assign w_unused_pc_seq = ^i_pc_seq;

  assign w_op     = br_op_e'(i_br_op);
  assign w_accept = i_br_valid & (r_state == StIdle);
  assign w_take   = w_accept & br_is_taken(w_op, i_eq);
  assign w_count  = w_accept & (w_op != BR_NOP);

  always_comb begin
    w_state_d = r_state;
    w_fcnt_d  = r_fcnt;
    unique case (r_state)
      StIdle: begin
        if (w_take) w_state_d = StRedir;
      end
      StRedir: begin
        // Flush cycles still owed after this one.
        w_fcnt_d  = 4'(FLUSH_CYC - 1);
        w_state_d = (FLUSH_CYC > 1) ? StFlush : StIdle;
      end
      StFlush: begin
        if (r_fcnt <= 4'd1) begin
          w_fcnt_d  = '0;
          w_state_d = StIdle;
        end else begin
          w_fcnt_d = r_fcnt - 4'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_fcnt        <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_state <= w_state_d;
      r_fcnt  <= w_fcnt_d;
      if (w_take) r_redirect_pc <= i_pc_tgt;
    end
  end

  // Outputs decode only registered state, so no input-to-output path exists
  // and an asynchronous reset drops them immediately.
  assign o_br_ready    = (r_state == StIdle);
  assign o_redirect    = (r_state == StRedir);
  assign o_flush       = (r_state != StIdle);
  assign o_redirect_pc = r_redirect_pc;

  branch_resolve_br_stat_ctr #(
    .CW(CW)
  ) u_br_ctr (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_inc  (w_count),
    .o_cnt  (o_br_cnt)
  );

  branch_resolve_br_stat_ctr #(
    .CW(CW)
  ) u_taken_ctr (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_inc  (w_take),
    .o_cnt  (o_taken_cnt)
  );

endmodule
